// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//
// Pipeline stage register with a valid/ready handshake and a 2-entry skid
// buffer. Each entry is {CTRL, RD, DATA}. The entry at the head is presented
// on OUT_*. IN_READY depends only on registered state, so there is no
// combinational path from OUT_READY to IN_READY.
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   FLUSH             synchronous flush, discards all buffered entries
//   IN_VALID/READY    upstream handshake
//   IN_CTRL/RD/DATA   upstream entry
//   OUT_VALID/READY   downstream handshake
//   OUT_CTRL/RD/DATA  head entry
//   OUT_WEN           OUT_VALID & OUT_CTRL[0]
//   OCCUPANCY         number of buffered entries (0..2)
//   STALL_CNT         saturating count of cycles with OUT_VALID & !OUT_READY
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | nothing buffered, OUT_VALID=0
// ST_ONE   | head entry in main register
// ST_FULL  | head in main, next entry in skid, IN_READY=0
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 2,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [CTRL_W-1:0] IN_CTRL,
    input  logic [RD_W-1:0]   IN_RD,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [RD_W-1:0]   OUT_RD,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_WEN,
    output logic [1:0]        OCCUPANCY,
    output logic [CNT_W-1:0]  STALL_CNT
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [RD_W-1:0]   main_rd,   skid_rd;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CNT_W-1:0]  stall_cnt;

    logic acc;
    logic pop;
    logic main_load_in;
    logic main_load_skid;
    logic skid_load;

    assign IN_READY  = (state != ST_FULL);
    assign OUT_VALID = (state != ST_EMPTY);
    assign acc       = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;

    // Payload moves are suppressed during a flush so the registers keep
    // their values; the state change alone discards the entries.
    assign main_load_in   = ~FLUSH & acc & ((state == ST_EMPTY) | ((state == ST_ONE) & pop));
    assign main_load_skid = ~FLUSH & (state == ST_FULL) & pop;
    assign skid_load      = ~FLUSH & acc & (state == ST_ONE) & ~pop;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_EMPTY;
        end else if (FLUSH) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (acc) state <= ST_ONE;
                ST_ONE: begin
                    if (acc && !pop)      state <= ST_FULL;
                    else if (!acc && pop) state <= ST_EMPTY;
                end
                ST_FULL:  if (pop) state <= ST_ONE;
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            main_ctrl <= '0;
            main_rd   <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_rd   <= '0;
            skid_data <= '0;
        end else begin
            if (main_load_in) begin
                main_ctrl <= IN_CTRL;
                main_rd   <= IN_RD;
                main_data <= IN_DATA;
            end else if (main_load_skid) begin
                main_ctrl <= skid_ctrl;
                main_rd   <= skid_rd;
                main_data <= skid_data;
            end
            if (skid_load) begin
                skid_ctrl <= IN_CTRL;
                skid_rd   <= IN_RD;
                skid_data <= IN_DATA;
            end
        end
    end

    // Flush does not clear the counter; it only tracks downstream stalls.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt <= '0;
        end else if (OUT_VALID && !OUT_READY && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign OUT_CTRL  = main_ctrl;
    assign OUT_RD    = main_rd;
    assign OUT_DATA  = main_data;
    assign OUT_WEN   = OUT_VALID & main_ctrl[0];
    assign OCCUPANCY = state;
    assign STALL_CNT = stall_cnt;

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline stage register that replaces fixed per-stage registers such as MEM/WB.
- Carries a control field, a destination-register index and a data payload between two pipeline stages.
- Uses a valid/ready handshake backed by a 2-entry skid buffer, so back-pressure (cache miss, hazard) never drops or duplicates an instruction.
- Adds a synchronous flush and a saturating stall-cycle counter for performance monitoring.

Parameters:
DATA_W, 64, width of data payload (e.g. ALU result and memory read data concatenated).
CTRL_W, 2, width of control field; bit 0 is the register-file write enable.
RD_W, 5, width of destination register index.
CNT_W, 16, width of stall counter.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  reset, synchronous, active-high.
FLUSH  input  1  synchronous flush; discards all buffered entries.
IN_VALID  input  1  upstream entry valid.
IN_READY  output  1  stage can accept an entry this cycle.
IN_CTRL  input  CTRL_W  upstream control field.
IN_RD  input  RD_W  upstream destination index.
IN_DATA  input  DATA_W  upstream payload.
OUT_VALID  output  1  downstream entry valid.
OUT_READY  input  1  downstream accepts entry (deasserted on busywait).
OUT_CTRL  output  CTRL_W  control field of head entry.
OUT_RD  output  RD_W  destination index of head entry.
OUT_DATA  output  DATA_W  payload of head entry.
OUT_WEN  output  1  OUT_VALID & OUT_CTRL[0]; gated register-file write enable.
OCCUPANCY  output  2  number of buffered entries (0, 1 or 2).
STALL_CNT  output  CNT_W  saturating count of cycles with OUT_VALID=1 and OUT_READY=0.

Behaviour:
- Storage: a main register (drives the OUT_* ports) and a skid register, each holding {CTRL, RD, DATA}.
- State: EMPTY(0), ONE(1), FULL(2); OCCUPANCY equals the state encoding.
- Handshakes: acc = IN_VALID & IN_READY; pop = OUT_VALID & OUT_READY.
- IN_READY = (state != FULL). It is a function of registered state only, with no combinational path from OUT_READY.
- OUT_VALID = (state != EMPTY).
- Transitions:
  - EMPTY: acc -> ONE, main <= IN.
  - ONE: acc & pop -> ONE, main <= IN. acc & !pop -> FULL, skid <= IN. !acc & pop -> EMPTY. Otherwise hold.
  - FULL: pop -> ONE, main <= skid. Otherwise hold. acc is impossible because IN_READY=0.
- Latency: an entry accepted at edge N is presented on OUT_* immediately after edge N (1 cycle) when the stage is empty or draining.
- Ordering: entries leave strictly in acceptance order.
- Hold: OUT_CTRL, OUT_RD and OUT_DATA must not change while OUT_VALID=1 and OUT_READY=0.
- Payload registers are not cleared on pop. In EMPTY, OUT_* hold stale values but OUT_VALID=0 and OUT_WEN=0.
- FLUSH (synchronous):
  - Next state EMPTY; both entries discarded; an acc in the same cycle is discarded.
  - A pop in the same cycle still completes downstream, since the downstream saw a valid handshake.
  - Payload registers hold their values.
- RESET (synchronous, priority over FLUSH and all handshakes):
  - state EMPTY, so OUT_VALID=0, OUT_WEN=0, OCCUPANCY=0, IN_READY=1 from the first cycle after reset.
  - main and skid payloads = 0, so OUT_CTRL=0, OUT_RD=0, OUT_DATA=0.
  - STALL_CNT=0.
- Reset mid-operation: buffered entries are lost; no write enable is emitted afterwards.
- STALL_CNT:
  - Increments by 1 at each edge where OUT_VALID=1 and OUT_READY=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by RESET; FLUSH does not clear it.
- All outputs are glitch-free registered values or simple AND/compare of registers. No #delays in RTL.

Test Plan:
- Reset: RESET=1 for 2 cycles with IN_VALID=1, IN_DATA=0xDEAD -> OUT_VALID=0, OUT_DATA=0, OUT_WEN=0, OCCUPANCY=0, IN_READY=1, STALL_CNT=0.
- Streaming: OUT_READY=1, three back-to-back entries RD=1,2,3, CTRL=2'b01 -> OUT_RD 1,2,3 on consecutive cycles, each 1 cycle after acceptance; OUT_WEN=1 for each; OCCUPANCY never exceeds 1.
- Back-pressure: OUT_READY=0, send RD=4 then RD=5 -> OCCUPANCY=2, IN_READY=0, OUT_RD stays 4. Raise OUT_READY -> RD=4 then RD=5 delivered, none lost or duplicated. STALL_CNT equals the number of stalled cycles.
- Flush: OCCUPANCY=2, assert FLUSH with IN_VALID=1 (RD=7) -> next cycle OCCUPANCY=0, OUT_VALID=0; RD=7 never appears on output.
- Saturation: CNT_W=4, hold OUT_VALID=1, OUT_READY=0 for 20 cycles -> STALL_CNT=15 and stays 15.
- Random: random IN_VALID/OUT_READY/FLUSH over 10k cycles against a queue model -> output order and content match; IN_READY=0 exactly when OCCUPANCY=2.
